// File: rtl/address_sequencer_pkg.sv
// Shared types and width helpers for the address sequencer.
package address_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARM,
    S_PACED,
    S_TAIL,
    S_FINISH
  } state_t;

  // Bits needed to hold the values 0..n (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/address_sequencer_if.sv
// Control/status bundle between the sequencer and its controller.
// The sequencer uses the slave view; the controller uses the master view.
interface address_sequencer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned TAIL_W = 3,
  parameter int unsigned CNT_W  = 3
);
  logic              start;
  logic              hold;
  logic              auto_restart;
  logic [ADDR_W-1:0] address;
  logic              done;
  logic [TAIL_W-1:0] tail_idx;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              finished;

  modport master (
    output start, hold, auto_restart,
    input  address, done, tail_idx, count, busy, finished
  );

  modport slave (
    input  start, hold, auto_restart,
    output address, done, tail_idx, count, busy, finished
  );
endinterface

// File: rtl/address_sequencer_pace_counter.sv
// Modulo-STRIDE pace counter: clear beats enable; neither asserted holds the value.
// o_tick flags the terminal count (STRIDE-1), where the next enable wraps to 0.
module address_sequencer_pace_counter
  import address_sequencer_pkg::*;
#(
  parameter int unsigned STRIDE = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_en,
  output logic [cnt_width(STRIDE)-1:0]  o_count,
  output logic                          o_tick
);
  localparam int unsigned CNT_W = cnt_width(STRIDE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRIDE - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_tick;

  assign w_tick  = (r_count == CNT_LAST);
  assign o_tick  = w_tick;
  assign o_count = r_count;

  // Count register: clear, wrap at terminal count, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_tick ? '0 : r_count + 1'b1;
    end
  end
endmodule

// File: rtl/address_sequencer.sv
// Address sequencer: full-rate warm-up sweep, paced sweep, done tail, finish.
// Supports synchronous restart, hold (freeze) and automatic restart from FINISH.
module address_sequencer
  import address_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned SWEEP_LEN = 64,
  parameter int unsigned WARMUP    = 15,
  parameter int unsigned STRIDE    = 6,
  parameter int unsigned NUM_TAIL  = 5
) (
  input logic               clk,
  input logic               rst,
  address_sequencer_if.slave bus
);
  localparam int unsigned TAIL_W = cnt_width(NUM_TAIL);
  localparam int unsigned CNT_W  = cnt_width(STRIDE);
  localparam int unsigned WARM_W = cnt_width(WARMUP);
  localparam int unsigned WARM_STOP_I = (WARMUP == 0) ? 0 : WARMUP - 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SWEEP_LEN - 1);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(NUM_TAIL);
  localparam logic [WARM_W-1:0] WARM_STOP = WARM_W'(WARM_STOP_I);
  // With no warm-up the sweep is paced from its first advance, so the
  // (otherwise unobservable) warm phase is skipped entirely.
  localparam state_t ENTRY_STATE = (WARMUP == 0) ? S_PACED : S_WARM;

  state_t              r_state,    w_state_nxt;
  logic [ADDR_W-1:0]   r_address,  w_address_nxt;
  logic [WARM_W-1:0]   r_warm_cnt, w_warm_cnt_nxt;
  logic [TAIL_W-1:0]   r_tail_idx, w_tail_idx_nxt;
  logic                r_done,     w_done_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                r_finished, w_finished_nxt;

  logic                w_cnt_clear;
  logic                w_cnt_en;
  logic [CNT_W-1:0]    w_count;
  logic                w_tick;
  logic                w_last;

  assign w_last = (r_address == LAST_ADDR);

  address_sequencer_pace_counter #(
    .STRIDE (STRIDE)
  ) u_pace (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cnt_clear),
    .i_en    (w_cnt_en),
    .o_count (w_count),
    .o_tick  (w_tick)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_address  <= '0;
      r_warm_cnt <= '0;
      r_tail_idx <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_address  <= w_address_nxt;
      r_warm_cnt <= w_warm_cnt_nxt;
      r_tail_idx <= w_tail_idx_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_finished <= w_finished_nxt;
    end
  end

  // Next-state and next-output logic: start > hold > normal sequencing.
  always_comb begin
    w_state_nxt    = r_state;
    w_address_nxt  = r_address;
    w_warm_cnt_nxt = r_warm_cnt;
    w_tail_idx_nxt = r_tail_idx;
    w_done_nxt     = r_done;
    w_busy_nxt     = r_busy;
    w_finished_nxt = r_finished;
    w_cnt_clear    = 1'b0;
    w_cnt_en       = 1'b0;

    if (bus.start || (!bus.hold && (r_state == S_FINISH) && bus.auto_restart)) begin
      w_state_nxt    = ENTRY_STATE;
      w_address_nxt  = '0;
      w_warm_cnt_nxt = '0;
      w_tail_idx_nxt = '0;
      w_done_nxt     = 1'b0;
      w_busy_nxt     = 1'b1;
      w_finished_nxt = 1'b0;
      w_cnt_clear    = 1'b1;
    end else if (!bus.hold) begin
      unique case (r_state)
        S_IDLE: begin
        end
        S_WARM, S_PACED: begin
          if (w_last) begin
            w_state_nxt    = S_TAIL;
            w_done_nxt     = 1'b1;
            w_tail_idx_nxt = TAIL_W'(1);
            w_cnt_clear    = 1'b1;
          end else if (r_state == S_WARM) begin
            w_address_nxt  = r_address + 1'b1;
            w_warm_cnt_nxt = r_warm_cnt + 1'b1;
            if (r_warm_cnt == WARM_STOP) begin
              w_state_nxt = S_PACED;
            end
          end else begin
            w_cnt_en = 1'b1;
            if (w_tick) begin
              w_address_nxt = r_address + 1'b1;
            end
          end
        end
        S_TAIL: begin
          if (r_tail_idx == TAIL_LAST) begin
            w_state_nxt    = S_FINISH;
            w_done_nxt     = 1'b0;
            w_tail_idx_nxt = '0;
            w_busy_nxt     = 1'b0;
            w_finished_nxt = 1'b1;
          end else begin
            w_tail_idx_nxt = r_tail_idx + 1'b1;
          end
        end
        S_FINISH: begin
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.address  = r_address;
  assign bus.done     = r_done;
  assign bus.tail_idx = r_tail_idx;
  assign bus.count    = w_count;
  assign bus.busy     = r_busy;
  assign bus.finished = r_finished;
endmodule

// File: tb/tb_address_sequencer.sv
// Bench for address_sequencer: two configurations driven in lockstep, each
// checked every cycle against a closed-form timeline model, plus literal
// expectations for the headline timing numbers.
module tb_address_sequencer;
  import address_sequencer_pkg::*;

  localparam int unsigned A_AW = 6, A_SL = 64, A_WU = 15, A_ST = 6, A_NT = 5;
  localparam int unsigned B_AW = 3, B_SL = 8,  B_WU = 0,  B_ST = 1, B_NT = 5;

  logic clk = 1'b0;
  logic rst;
  logic start, hold, ar;

  address_sequencer_if #(.ADDR_W(A_AW), .TAIL_W(cnt_width(A_NT)), .CNT_W(cnt_width(A_ST))) bus_a ();
  address_sequencer_if #(.ADDR_W(B_AW), .TAIL_W(cnt_width(B_NT)), .CNT_W(cnt_width(B_ST))) bus_b ();

  assign bus_a.start = start;
  assign bus_a.hold = hold;
  assign bus_a.auto_restart = ar;
  assign bus_b.start = start;
  assign bus_b.hold = hold;
  assign bus_b.auto_restart = ar;

  address_sequencer #(.ADDR_W(A_AW), .SWEEP_LEN(A_SL), .WARMUP(A_WU), .STRIDE(A_ST), .NUM_TAIL(A_NT))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  address_sequencer #(.ADDR_W(B_AW), .SWEEP_LEN(B_SL), .WARMUP(B_WU), .STRIDE(B_ST), .NUM_TAIL(B_NT))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // t = number of unheld edges since the sweep (re)started.
  function automatic int sweep_t0(input int sl, input int wu, input int st);
    int last;
    last = sl - 1;
    return (wu >= last) ? last : wu + (last - wu) * st;
  endfunction

  function automatic int next_t(input bit started, input int t, input bit s, input bit h,
                                input bit a, input int sl, input int wu, input int st, input int nt);
    if (s) return 0;
    if (h || !started) return t;
    if (t == sweep_t0(sl, wu, st) + nt + 1) return a ? 0 : t;
    return t + 1;
  endfunction

  function automatic void model_out(input bit started, input int t, input int sl, input int wu,
                                    input int st, input int nt, output int addr, output int dn,
                                    output int tl, output int cn, output int bs, output int fn);
    int t0;
    t0 = sweep_t0(sl, wu, st);
    addr = 0; dn = 0; tl = 0; cn = 0; bs = 0; fn = 0;
    if (!started) return;
    if (t <= t0) begin
      bs = 1;
      if (t <= wu) begin
        addr = t;
      end else begin
        addr = wu + (t - wu) / st;
        cn   = (t - wu) % st;
      end
    end else if (t <= t0 + nt) begin
      bs = 1; dn = 1; tl = t - t0; addr = sl - 1;
    end else begin
      fn = 1; addr = sl - 1;
    end
  endfunction

  bit ma_s, mb_s;
  int ma_t, mb_t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_s <= 1'b0; ma_t <= 0;
      mb_s <= 1'b0; mb_t <= 0;
    end else begin
      ma_t <= next_t(ma_s, ma_t, start, hold, ar, A_SL, A_WU, A_ST, A_NT);
      mb_t <= next_t(mb_s, mb_t, start, hold, ar, B_SL, B_WU, B_ST, B_NT);
      ma_s <= ma_s | start;
      mb_s <= mb_s | start;
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    int ea, ed, et, ec, eb, ef;
    model_out(ma_s, ma_t, A_SL, A_WU, A_ST, A_NT, ea, ed, et, ec, eb, ef);
    check("a.address",  int'(bus_a.address),  ea);
    check("a.done",     int'(bus_a.done),     ed);
    check("a.tail_idx", int'(bus_a.tail_idx), et);
    check("a.count",    int'(bus_a.count),    ec);
    check("a.busy",     int'(bus_a.busy),     eb);
    check("a.finished", int'(bus_a.finished), ef);
    model_out(mb_s, mb_t, B_SL, B_WU, B_ST, B_NT, ea, ed, et, ec, eb, ef);
    check("b.address",  int'(bus_b.address),  ea);
    check("b.done",     int'(bus_b.done),     ed);
    check("b.tail_idx", int'(bus_b.tail_idx), et);
    check("b.count",    int'(bus_b.count),    ec);
    check("b.busy",     int'(bus_b.busy),     eb);
    check("b.finished", int'(bus_b.finished), ef);
  end

  // ---------------- directed + random stimulus ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus_a.done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc, n, hcnt;
    bit held;
    rst = 1'b1; start = 1'b0; hold = 1'b0; ar = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.address", int'(bus_a.address), 0);
    check("reset.busy", int'(bus_a.busy), 0);
    check("reset.finished", int'(bus_a.finished), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle.busy", int'(bus_a.busy), 0);

    // Full default sweep, small config sweeping alongside.
    pulse_start();
    check("A.start.address", int'(bus_a.address), 0);
    check("A.start.busy", int'(bus_a.busy), 1);
    cyc = 0;
    while (!bus_a.done && cyc < 1000) begin
      if (cyc <= 7)  check("B.addr_seq", int'(bus_b.address), cyc);
      if (cyc == 8)  check("B.first_done", int'(bus_b.done), 1);
      if (cyc <= 15) check("A.warm_addr", int'(bus_a.address), cyc);
      if (cyc == 20) check("A.count_at5", int'(bus_a.count), 5);
      if (cyc == 21) check("A.addr16", int'(bus_a.address), 16);
      @(negedge clk);
      cyc++;
    end
    check("A.first_done_cycles", cyc, 304);
    n = 0;
    while (bus_a.done && n < 20) begin
      check("A.tail_idx", int'(bus_a.tail_idx), n + 1);
      n++;
      @(negedge clk);
    end
    check("A.done_len", n, 5);
    check("A.finished", int'(bus_a.finished), 1);
    check("A.final_addr", int'(bus_a.address), 63);
    check("A.final_busy", int'(bus_a.busy), 0);

    // Hold for 3 cycles inside the tail at tail_idx=2.
    pulse_start();
    wait_done(cyc);
    n = 0; held = 1'b0; hcnt = 0;
    while (bus_a.done && n < 30) begin
      n++;
      if (bus_a.tail_idx == 2 && !held) begin
        hold = 1'b1; held = 1'b1; hcnt = 0;
      end else if (hold) begin
        hcnt++;
        if (hcnt == 3) hold = 1'b0;
      end
      @(negedge clk);
    end
    hold = 1'b0;
    check("B.held_done_len", n, 8);

    // Restart while paced at address 40.
    pulse_start();
    cyc = 0;
    while (bus_a.address != 40 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check("C.count_before", int'(bus_a.count), 2);
    pulse_start();
    check("C.address", int'(bus_a.address), 0);
    check("C.count", int'(bus_a.count), 0);
    check("C.busy", int'(bus_a.busy), 1);
    check("C.done", int'(bus_a.done), 0);

    // Start and hold together: start wins.
    repeat (30) @(negedge clk);
    check("D.addr_before", int'(bus_a.address), 17);
    hold = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("D.address", int'(bus_a.address), 0);
    check("D.busy", int'(bus_a.busy), 1);
    @(negedge clk);
    check("D.held_addr", int'(bus_a.address), 0);
    hold = 1'b0;
    @(negedge clk);
    check("D.resume_addr", int'(bus_a.address), 1);

    // Auto-restart: one FINISH cycle, then identical second sweep.
    ar = 1'b1;
    cyc = 0;
    while (!bus_a.finished && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("E.finished", int'(bus_a.finished), 1);
    @(negedge clk);
    check("E.finish_len", int'(bus_a.finished), 0);
    check("E.address", int'(bus_a.address), 0);
    check("E.busy", int'(bus_a.busy), 1);
    wait_done(cyc);
    check("E.second_sweep_cycles", cyc, 304);
    ar = 1'b0;
    repeat (8) @(negedge clk);

    // Asynchronous reset mid-cycle.
    pulse_start();
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("F.address", int'(bus_a.address), 0);
    check("F.count", int'(bus_a.count), 0);
    check("F.busy", int'(bus_a.busy), 0);
    check("F.b_address", int'(bus_b.address), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("F.idle_busy", int'(bus_a.busy), 0);

    // Randomized traffic.
    ar = 1'b1;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 299) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) ar = ~ar;
      @(negedge clk);
    end
    start = 1'b0; hold = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
